// File: rtl/camera_pixel_unpacker.sv
// Pairs bytes popped from a first-word-fall-through FIFO into RGB565 pixels with frame position tags.
// Latency: the pixel is valid in the cycle after the edge that pops its second byte; one-deep output register.
// Backpressure: with a pixel pending and m_ready low, the second byte of the next pixel is not popped, so the FIFO backs up.
module camera_pixel_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               enable,
  input  logic                                               resync,
  input  logic                                               fifo_empty,
  input  logic [DATA_WIDTH-1:0]                              fifo_data,
  output logic                                               fifo_read,
  output logic [2*DATA_WIDTH-1:0]                            m_data,
  output logic                                               m_valid,
  input  logic                                               m_ready,
  output logic                                               m_sof,
  output logic                                               m_eol,
  output logic                                               m_eof,
  output logic [((H_PIXELS > 1) ? $clog2(H_PIXELS) : 1)-1:0] pixel_x,
  output logic [((V_LINES > 1) ? $clog2(V_LINES) : 1)-1:0]   line_y,
  output logic                                               frame_done
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  phase_t                  r_phase;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic [2*DATA_WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_sof;
  logic                    r_eol;
  logic                    r_eof;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic                    r_frame_done;

  logic                    w_slot_free;
  logic                    w_pop;
  logic                    w_load;
  logic                    w_handshake;
  logic                    w_x_last;
  logic                    w_y_last;
  logic [2*DATA_WIDTH-1:0] w_pixel;

  // A HI byte only fills the hold register, so it may be popped even while the output slot is occupied.
  assign w_slot_free = !r_valid || m_ready;
  assign w_pop       = rst_n && enable && !resync && !fifo_empty && ((r_phase == PH_HI) || w_slot_free);
  assign w_load      = w_pop && (r_phase == PH_LO);
  assign w_handshake = r_valid && m_ready;
  assign w_x_last    = (r_x == XW'(H_PIXELS - 1));
  assign w_y_last    = (r_y == YW'(V_LINES - 1));
  assign w_pixel     = MSB_FIRST ? {r_hold, fifo_data} : {fifo_data, r_hold};

  // Byte phase, output register, frame counters and frame_done pulse; resync clears like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || resync) begin
      r_phase      <= PH_HI;
      r_hold       <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_eof        <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_handshake && r_eof;

      if (w_pop) begin
        if (r_phase == PH_HI) begin
          r_hold  <= fifo_data;
          r_phase <= PH_LO;
        end else begin
          r_phase <= PH_HI;
        end
      end

      if (w_load) begin
        r_data  <= w_pixel;
        r_valid <= 1'b1;
        r_sof   <= (r_x == '0) && (r_y == '0);
        r_eol   <= w_x_last;
        r_eof   <= w_x_last && w_y_last;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign fifo_read  = w_pop;
  assign m_data     = r_data;
  assign m_valid    = r_valid;
  assign m_sof      = r_sof;
  assign m_eol      = r_eol;
  assign m_eof      = r_eof;
  assign pixel_x    = r_x;
  assign line_y     = r_y;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_camera_pixel_unpacker.sv
// Bench for camera_pixel_unpacker: a 4x2 frame, one MSB-first and one LSB-first instance sharing a FIFO model.
// Inputs change 1 time unit after each rising edge; outputs are compared against a pixel-level model there.
module tb_camera_pixel_unpacker;

  localparam int H = 4;
  localparam int V = 2;

  logic       clk;
  logic       rst_n, enable, resync, fifo_empty, m_ready;
  logic [7:0] fifo_data;
  logic       rd0, rd1, v0, v1, sof0, sof1, eol0, eol1, eof0, eof1, fd0, fd1;
  logic [15:0] d0, d1;
  logic [1:0] px0, px1;
  logic [0:0] ly0, ly1;

  camera_pixel_unpacker #(.DATA_WIDTH(8), .H_PIXELS(H), .V_LINES(V), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .resync(resync), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(rd0), .m_data(d0), .m_valid(v0), .m_ready(m_ready),
    .m_sof(sof0), .m_eol(eol0), .m_eof(eof0), .pixel_x(px0), .line_y(ly0), .frame_done(fd0));

  camera_pixel_unpacker #(.DATA_WIDTH(8), .H_PIXELS(H), .V_LINES(V), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .resync(resync), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(rd1), .m_data(d1), .m_valid(v1), .m_ready(m_ready),
    .m_sof(sof1), .m_eol(eol1), .m_eof(eof1), .pixel_x(px1), .line_y(ly1), .frame_done(fd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int fd_cnt = 0;

  logic [7:0]  q[$];
  logic [18:0] cap0[$];   // {sof, eol, eof, data} of pixels accepted from the MSB-first instance
  logic [15:0] cap1[$];   // data of pixels accepted from the LSB-first instance
  logic        gate = 1'b0;
  logic        toggle = 1'b0;

  // Pixel-level model: a held byte (if any), a pending pixel and a linear pixel index within the frame.
  logic        m_have;
  logic [7:0]  m_hold;
  logic        m_pv;
  logic [15:0] m_pdat;
  logic        m_psof, m_peol, m_peof, m_fd;
  int          m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0; m_hold = '0; m_pv = 1'b0; m_pdat = '0;
    m_psof = 1'b0; m_peol = 1'b0; m_peof = 1'b0; m_fd = 1'b0; m_idx = 0;
  endtask

  task automatic update_inputs();
    if (toggle) gate = ~gate;
    fifo_empty = (q.size() == 0) || gate;
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic step();
    logic rd_exp, rd_act, hs, loaded;
    #1;
    rd_exp = rst_n && enable && !resync && !fifo_empty && (!m_have || !m_pv || m_ready);
    rd_act = rd0;
    chk("fifo_read", rd0, rd_exp);
    chk("fifo_read_lsb", rd1, rd_exp);
    chk("read_while_empty", rd0 & fifo_empty, 0);
    if (v0 === 1'b1 && m_ready) cap0.push_back({sof0, eol0, eof0, d0});
    if (v1 === 1'b1 && m_ready) cap1.push_back(d1);
    if (rd_act) pops++;
    hs = m_pv && m_ready;
    if (!rst_n || resync) begin
      model_reset();
    end else begin
      m_fd = hs && m_peof;
      loaded = 1'b0;
      if (rd_exp) begin
        if (!m_have) begin
          m_hold = fifo_data;
          m_have = 1'b1;
        end else begin
          m_pdat = {m_hold, fifo_data};
          m_psof = (m_idx == 0);
          m_peol = ((m_idx % H) == H - 1);
          m_peof = (m_idx == H * V - 1);
          m_idx  = (m_idx + 1) % (H * V);
          m_have = 1'b0;
          loaded = 1'b1;
        end
      end
      if (loaded) m_pv = 1'b1;
      else if (hs) m_pv = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rd_act && q.size() != 0) void'(q.pop_front());
    chk("m_valid", v0, m_pv);
    chk("m_valid_lsb", v1, m_pv);
    if (m_pv) begin
      chk("m_data", d0, m_pdat);
      chk("m_data_lsb", d1, {m_pdat[7:0], m_pdat[15:8]});
      chk("tags", {sof0, eol0, eof0}, {m_psof, m_peol, m_peof});
      chk("tags_lsb", {sof1, eol1, eof1}, {m_psof, m_peol, m_peof});
    end
    chk("frame_done", fd0, m_fd);
    chk("frame_done_lsb", fd1, m_fd);
    chk("pixel_x", px0, m_idx % H);
    chk("line_y", ly0, m_idx / H);
    chk("pixel_x_lsb", px1, m_idx % H);
    if (fd0 === 1'b1) fd_cnt++;
    update_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_range(input int first, input int last);
    for (int b = first; b <= last; b++) q.push_back(8'(b));
    update_inputs();
  endtask

  task automatic resync_pulse();
    resync = 1'b1;
    step();
    resync = 1'b0;
    update_inputs();
  endtask

  initial begin
    int p0;
    model_reset();
    rst_n = 1'b0; enable = 1'b1; resync = 1'b0; m_ready = 1'b1;
    q.push_back(8'h55); q.push_back(8'h66);
    update_inputs();

    // Reset state, with bytes available that must not be popped.
    run(2);
    chk("rst_fifo_read", rd0, 0);
    chk("rst_m_valid", v0, 0);
    chk("rst_m_data", d0, 16'h0000);
    chk("rst_pos", {px0, ly0}, 0);
    chk("rst_frame_done", fd0, 0);
    q.delete();
    rst_n = 1'b1;
    update_inputs();

    // Full 4x2 frame, continuous flow.
    cap0.delete(); cap1.delete(); fd_cnt = 0;
    push_range(1, 16);
    run(22);
    chk("frame_count", cap0.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("frame_pixel", cap0[k], {k == 0, (k % 4) == 3, k == 7, 8'(2 * k + 1), 8'(2 * k + 2)});
    chk("frame_first", cap0[0], {3'b100, 16'h0102});
    chk("frame_last", cap0[7], {3'b011, 16'h0F10});
    chk("frame_done_pulses", fd_cnt, 1);
    chk("frame_pos_wrap", {px0, ly0}, 0);

    // Byte order of the LSB-first instance.
    cap0.delete(); cap1.delete();
    q.push_back(8'hAB); q.push_back(8'hCD); update_inputs();
    run(4);
    chk("lsb_first_count", cap1.size(), 1);
    chk("lsb_first_data", cap1[0], 16'hCDAB);
    chk("msb_first_data", cap0[0][15:0], 16'hABCD);

    // Backpressure: only the next HI byte is popped while a pixel is pending.
    resync_pulse();
    m_ready = 1'b0; pops = 0; cap0.delete();
    push_range(1, 6);
    run(12);
    chk("stall_pops", pops, 3);
    chk("stall_data", d0, 16'h0102);
    chk("stall_valid", v0, 1);
    m_ready = 1'b1;
    run(10);
    chk("stall_drain_count", cap0.size(), 3);
    chk("stall_drain_0", cap0[0], {3'b100, 16'h0102});
    chk("stall_drain_1", cap0[1][15:0], 16'h0304);
    chk("stall_drain_2", cap0[2][15:0], 16'h0506);

    // FIFO empty flag toggling every cycle gives the same pixel stream.
    resync_pulse();
    cap0.delete(); fd_cnt = 0; toggle = 1'b1;
    push_range(1, 16);
    run(44);
    toggle = 1'b0; gate = 1'b0; update_inputs();
    chk("toggle_count", cap0.size(), 8);
    for (int k = 0; k < cap0.size() && k < 8; k++)
      chk("toggle_pixel", cap0[k], {k == 0, (k % 4) == 3, k == 7, 8'(2 * k + 1), 8'(2 * k + 2)});
    chk("toggle_frame_done", fd_cnt, 1);

    // Enable low with phase LO: no pops, held byte kept.
    resync_pulse();
    cap0.delete();
    q.push_back(8'h11); update_inputs();
    run(1);
    enable = 1'b0; p0 = pops;
    q.push_back(8'h22); q.push_back(8'h33); update_inputs();
    run(5);
    chk("disabled_pops", pops - p0, 0);
    chk("disabled_valid", v0, 0);
    enable = 1'b1; update_inputs();
    run(4);
    chk("reenable_pixel", cap0[0][15:0], 16'h1122);

    // Resync mid-line with a pending pixel and a held byte.
    resync_pulse();
    m_ready = 1'b1;
    push_range(1, 2);
    run(4);
    m_ready = 1'b0;
    push_range(3, 5);
    run(5);
    chk("pre_resync_x", px0, 2);
    chk("pre_resync_valid", v0, 1);
    resync_pulse();
    chk("resync_valid", v0, 0);
    chk("resync_pos", {px0, ly0}, 0);
    cap0.delete();
    q.delete();
    q.push_back(8'hAA); q.push_back(8'hBB);
    m_ready = 1'b1; update_inputs();
    run(4);
    chk("resync_next_pixel", cap0[0], {3'b100, 16'hAABB});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
